// File: rtl/iteration_sync_ctrl.sv
// Iteration barrier for per-core BFS pipelines: resets the cores, waits until every
// core reports end-of-iteration, then advances the shared iteration id or finishes.
module iteration_sync_ctrl #(
  parameter int CORE_NUM         = 32,
  parameter int ITERATION_DWIDTH = 8,
  parameter int MAX_ITER         = 255,
  parameter int RST_CYCLES       = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CORE_NUM-1:0]                  front_iteration_end,
  input  logic [CORE_NUM-1:0]                  front_iteration_end_valid,
  input  logic [CORE_NUM-1:0]                  front_active_v_valid,
  output logic [CORE_NUM-1:0]                  core_rst,
  output logic [CORE_NUM*ITERATION_DWIDTH-1:0] global_iteration_id,
  output logic                                 iteration_done,
  output logic                                 bfs_done,
  output logic                                 busy,
  output logic [2:0]                           o_dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CORE_RST = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_ADVANCE  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [3:0]                  RST_LOAD = 4'(RST_CYCLES - 1);
  localparam logic [ITERATION_DWIDTH-1:0] ID_MAX   = ITERATION_DWIDTH'(MAX_ITER);

  logic [2:0]                  r_state;
  logic [ITERATION_DWIDTH-1:0] r_id;
  logic [CORE_NUM-1:0]         r_mask;
  logic                        r_act;
  logic [3:0]                  r_cnt;
  logic [CORE_NUM-1:0]         r_core_rst;
  logic                        r_iter_done;
  logic                        r_bfs_done;
  logic                        r_busy;

  logic [2:0]                  w_state_nx;
  logic [ITERATION_DWIDTH-1:0] w_id_nx;
  logic [CORE_NUM-1:0]         w_mask_nx;
  logic                        w_act_nx;
  logic [3:0]                  w_cnt_nx;

  always_comb begin
    w_state_nx = r_state;
    w_id_nx    = r_id;
    w_mask_nx  = r_mask;
    w_act_nx   = r_act;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx = S_CORE_RST;
          w_id_nx    = '0;
          w_mask_nx  = '0;
          w_act_nx   = 1'b0;
          w_cnt_nx   = RST_LOAD;
        end
      end
      S_CORE_RST: begin
        if (r_cnt == 4'd0) w_state_nx = S_RUN;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      S_RUN: begin
        // Bits and activity captured this cycle count toward the barrier decision.
        w_mask_nx = r_mask | (front_iteration_end & front_iteration_end_valid);
        w_act_nx  = r_act | (|front_active_v_valid);
        if (&w_mask_nx) w_state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (!r_act || (r_id == ID_MAX)) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_RUN;
          w_id_nx    = r_id + 1'b1;
          w_mask_nx  = '0;
          w_act_nx   = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      r_mask      <= '0;
      r_act       <= 1'b0;
      r_cnt       <= 4'd0;
      r_core_rst  <= '1;
      r_iter_done <= 1'b0;
      r_bfs_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_id        <= w_id_nx;
      r_mask      <= w_mask_nx;
      r_act       <= w_act_nx;
      r_cnt       <= w_cnt_nx;
      r_core_rst  <= {CORE_NUM{w_state_nx == S_CORE_RST}};
      r_iter_done <= (w_state_nx == S_ADVANCE);
      r_bfs_done  <= (w_state_nx == S_DONE);
      r_busy      <= (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
    end
  end

  assign core_rst            = r_core_rst;
  assign global_iteration_id = {CORE_NUM{r_id}};
  assign iteration_done      = r_iter_done;
  assign bfs_done            = r_bfs_done;
  assign busy                = r_busy;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_iteration_sync_ctrl.sv
// Directed bench for iteration_sync_ctrl: a 4-core default instance and a 4-core
// instance with MAX_ITER=2, sharing the front-end inputs.
module tb_iteration_sync_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start_m = 1'b0;
  logic [3:0]  fe = '0;
  logic [3:0]  fev = '0;
  logic [3:0]  fav = '0;

  logic [3:0]  core_rst, core_rst_m;
  logic [31:0] gid, gid_m;
  logic        idone, idone_m, bdone, bdone_m, busy, busy_m;
  logic [2:0]  dbg, dbg_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iteration_sync_ctrl #(.CORE_NUM(4), .ITERATION_DWIDTH(8), .MAX_ITER(255), .RST_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .front_iteration_end(fe), .front_iteration_end_valid(fev), .front_active_v_valid(fav),
    .core_rst(core_rst), .global_iteration_id(gid), .iteration_done(idone),
    .bfs_done(bdone), .busy(busy), .o_dbg_state(dbg)
  );

  iteration_sync_ctrl #(.CORE_NUM(4), .ITERATION_DWIDTH(8), .MAX_ITER(2), .RST_CYCLES(4)) dut_m (
    .clk(clk), .rst(rst), .start(start_m),
    .front_iteration_end(fe), .front_iteration_end_valid(fev), .front_active_v_valid(fav),
    .core_rst(core_rst_m), .global_iteration_id(gid_m), .iteration_done(idone_m),
    .bfs_done(bdone_m), .busy(busy_m), .o_dbg_state(dbg_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle of front-end stimulus, then inputs return to idle.
  task automatic drive(input logic [3:0] e, input logic [3:0] v, input logic [3:0] a);
    fe = e; fev = v; fav = a;
    tick();
    fe = '0; fev = '0; fav = '0;
  endtask

  task automatic full_iter();
    drive(4'hF, 4'hF, 4'h1);
    tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst_core_rst", core_rst, 32'hF);
    check("rst_busy", busy, 0);
    check("rst_bfs_done", bdone, 0);
    check("rst_idone", idone, 0);
    check("rst_gid", gid, 0);
    check("rst_state", dbg, 0);
    rst = 1'b1;
    tick();
    check("post_rst_core_rst", core_rst, 0);
    check("post_rst_state", dbg, 0);

    // Core reset hold of exactly 4 cycles
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_core_rst", core_rst, 32'hF);
      check("hold_busy", busy, 1);
      if (i < 3) tick();
    end
    tick();
    check("run_core_rst", core_rst, 0);
    check("run_state", dbg, 3'd2);
    check("run_gid", gid, 0);

    // Iteration 0: ends on distinct cycles with activity
    drive(4'b0001, 4'b0001, 4'b0001); check("it0_e0", idone, 0);
    drive(4'b0010, 4'b0010, 4'b0000); check("it0_e1", idone, 0);
    drive(4'b0100, 4'b0100, 4'b0000); check("it0_e2", idone, 0);
    drive(4'b1000, 4'b1000, 4'b0000);
    check("it0_idone", idone, 1);
    check("it0_gid_hold", gid, 0);
    tick();
    check("it0_idone_clr", idone, 0);
    check("it0_gid", gid, 32'h01010101);

    // Iteration 1: unqualified ends for core 2 must not advance
    drive(4'b1111, 4'b1011, 4'b0001); check("it1_c2_novalid", idone, 0);
    drive(4'b0000, 4'b0100, 4'b0000); check("it1_c2_noend", idone, 0);
    drive(4'b0001, 4'b0001, 4'b0000); check("it1_repeat", idone, 0);
    drive(4'b0100, 4'b0100, 4'b0000); check("it1_idone", idone, 1);
    tick();
    check("it1_gid", gid, 32'h02020202);

    // Iteration 2: start in RUN is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("run_start_ignored", core_rst, 0);
    check("run_start_gid", gid, 32'h02020202);
    full_iter();
    check("it2_gid", gid, 32'h03030303);

    // Iteration 3 with no activity terminates the traversal
    drive(4'hF, 4'hF, 4'h0);
    check("it3_idone", idone, 1);
    check("it3_bdone_early", bdone, 0);
    tick();
    check("done_bdone", bdone, 1);
    check("done_busy", busy, 0);
    check("done_gid", gid, 32'h03030303);
    check("done_idone", idone, 0);
    drive(4'hF, 4'hF, 4'hF);
    check("done_hold", bdone, 1);

    // MAX_ITER=2 instance stops without wrap
    start_m = 1'b1; tick(); start_m = 1'b0;
    check("m_core_rst", core_rst_m, 32'hF);
    tick(); tick(); tick(); tick();
    check("m_run_gid", gid_m, 0);
    full_iter();
    check("m_gid1", gid_m, 32'h01010101);
    full_iter();
    check("m_gid2", gid_m, 32'h02020202);
    drive(4'hF, 4'hF, 4'h1);
    check("m_idone", idone_m, 1);
    tick();
    check("m_bdone", bdone_m, 1);
    check("m_busy", busy_m, 0);
    check("m_gid_final", gid_m, 32'h02020202);
    check("main_unaffected", gid, 32'h03030303);

    // Restart from DONE, run to id 5, then abort with reset
    start = 1'b1; tick(); start = 1'b0;
    check("restart_bdone", bdone, 0);
    check("restart_gid", gid, 0);
    check("restart_core_rst", core_rst, 32'hF);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 5; i++) full_iter();
    check("pre_abort_gid", gid, 32'h05050505);
    check("pre_abort_state", dbg, 3'd2);
    rst = 1'b0; tick();
    check("abort_gid", gid, 0);
    check("abort_core_rst", core_rst, 32'hF);
    check("abort_busy", busy, 0);
    rst = 1'b1; tick();
    check("abort_release_core_rst", core_rst, 0);
    check("abort_release_state", dbg, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("rerun_gid", gid, 0);
    check("rerun_busy", busy, 1);
    check("rerun_core_rst", core_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iteration_sync_ctrl.md
ITERATION_SYNC_CTRL -- requirements
Module: iteration_sync_ctrl

Interface
REQ-001 SHALL have parameter CORE_NUM, default 32, number of per-core pipelines sequenced.
REQ-002 SHALL have parameter ITERATION_DWIDTH, default 8, iteration counter width.
REQ-003 SHALL have parameter MAX_ITER, default 255, last legal iteration id.
REQ-004 SHALL have parameter RST_CYCLES, default 4, core-reset hold length in cycles (range 1..15).
REQ-005 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port start  input  1  pulse launching a traversal.
REQ-008 SHALL have port front_iteration_end  input  CORE_NUM  per-core end-of-iteration flag.
REQ-009 SHALL have port front_iteration_end_valid  input  CORE_NUM  qualifies front_iteration_end.
REQ-010 SHALL have port front_active_v_valid  input  CORE_NUM  per-core active-vertex strobe (activity detection).
REQ-011 SHALL have port core_rst  output  CORE_NUM  per-core pipeline reset, active-high.
REQ-012 SHALL have port global_iteration_id  output  CORE_NUM*ITERATION_DWIDTH  current iteration id replicated per core.
REQ-013 SHALL have port iteration_done  output  1  one-cycle pulse per completed iteration.
REQ-014 SHALL have port bfs_done  output  1  traversal finished, level output.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE and DONE.

Function
REQ-016 SHALL implement FSM states IDLE, CORE_RST, RUN, ADVANCE, DONE.
REQ-017 IDLE: start=1 -> CORE_RST, iteration id cleared to 0, hold counter loaded; start=0 stays.
REQ-018 CORE_RST: core_rst all ones; counter counts RST_CYCLES cycles, then -> RUN; core_rst all zeros in every other non-reset state.
REQ-019 RUN: per-core done_mask bit i set when front_iteration_end[i] and front_iteration_end_valid[i] both 1; end=1 with valid=0, or valid=1 with end=0, SHALL not set it.
REQ-020 Repeated end events for an already-set bit SHALL be idempotent.
REQ-021 RUN: activity flag set when any front_active_v_valid bit is 1, including the same cycle the final done_mask bit sets.
REQ-022 RUN -> ADVANCE on the edge after which done_mask (including bits captured that cycle) is all ones.
REQ-023 ADVANCE lasts exactly one cycle; iteration_done=1 only in that cycle.
REQ-024 ADVANCE: if activity flag=0 or iteration id equals MAX_ITER -> DONE, id unchanged; else id incremented by 1, done_mask and activity flag cleared, -> RUN.
REQ-025 Iteration id SHALL never wrap; increments stop at MAX_ITER.
REQ-026 Inputs front_* arriving outside RUN SHALL be ignored (no mask/flag update).
REQ-027 DONE: bfs_done=1; start=1 -> CORE_RST with id cleared and bfs_done cleared next cycle; otherwise holds.
REQ-028 start in CORE_RST, RUN or ADVANCE SHALL be ignored.
REQ-029 All outputs SHALL be registered; global_iteration_id changes only on the edge leaving ADVANCE or entering CORE_RST.

Reset
REQ-030 rst=0 sampled at an edge SHALL force IDLE, id=0, done_mask=0, activity=0, counter=0, iteration_done=0, bfs_done=0, busy=0, core_rst all ones.
REQ-031 rst=0 mid-traversal (any state) SHALL abort immediately with REQ-030 values; first cycle after rst=1 core_rst all zeros, state IDLE.

Verification
REQ-032 CORE_NUM=4, start pulse -> core_rst=4'hF for exactly 4 cycles, busy=1, then RUN with id=0.
REQ-033 RUN, cores 0-3 end on distinct cycles with activity -> iteration_done single pulse one cycle after last end, id 0->1 next cycle.
REQ-034 RUN, core 2 end=1 with valid=0, others valid ends -> no ADVANCE until core 2 valid end arrives.
REQ-035 Iteration 3 with no front_active_v_valid, all ends -> iteration_done pulse, bfs_done=1, id stays 3, busy=0.
REQ-036 MAX_ITER=2, activity every iteration -> DONE after iteration 2, id=2, no wrap.
REQ-037 rst=0 during RUN at id=5 -> next cycle id=0, core_rst all ones, busy=0; start then restarts at id=0.
